hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core.
- Drives enable and flush controls for every inter-stage buffer: PC, fetch/decode, decode/execute (including the execute-stage PC buffer) and execute/memory.
- Detects load-use hazards and taken-branch redirects, and freezes the pipeline while data memory is not ready.
- Tracks memory-wait duration with a timeout that traps into a sticky error state, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 82 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline enable/flush sequencer with memory-wait timeout and stall counter
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             em_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       ctrl_state
);
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic freeze, load_use, hold;
  assign freeze = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // state and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
    end
  end
  // next state: count consecutive frozen cycles, trap after MAX_WAIT of them
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    case (state)
      RUN: if (freeze) begin
        state_nx = WAIT;
        wait_nx = 8'd1;
      end
      WAIT: if (!freeze) begin
        state_nx = RUN;
        wait_nx = 8'd0;
      end else if (wait_cnt == 8'(MAX_WAIT - 1)) state_nx = ERR;
      else wait_nx = wait_cnt + 8'd1;
      ERR: state_nx = ERR;
      default: begin
        state_nx = RUN;
        wait_nx = 8'd0;
      end
    endcase
  end
  // outputs: ERR/freeze hold everything, branch flushes, load-use inserts one bubble
  always_comb begin
    hold = (state == ERR) | freeze;
    pc_en = ~hold & (ex_branch_taken | ~load_use);
    fd_en = ~hold & (ex_branch_taken | ~load_use);
    fd_flush = ~hold & ex_branch_taken;
    de_en = ~hold;
    de_flush = ~hold & (ex_branch_taken | load_use);
    em_en = ~hold;
  end
  // saturating count of cycles the PC was held outside ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count <= '0;
    else if (state != ERR && !pc_en && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
  end
  assign mem_timeout = (state == ERR);
  assign ctrl_state = state;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors checked through an expectation queue
module tb_hazard_stall_ctrl;
  localparam logic [5:0] ALL = 6'b110101, FRZ = 6'b000000, BR = 6'b111111, LU = 6'b000111;
  typedef struct {logic [12:0] v; string nm;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mem_timeout;
  logic [3:0] stall_count;
  logic [1:0] ctrl_state;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  hazard_stall_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en), .de_flush(de_flush),
    .em_en(em_en), .mem_timeout(mem_timeout), .stall_count(stall_count), .ctrl_state(ctrl_state)
  );
  always #5 clk = ~clk;
  task automatic cyc(input string nm, input logic [4:0] r1, r2, input logic u1, u2,
                     input logic [4:0] rd, input logic mr, bt, rq, rdy,
                     input logic [5:0] ctl, input logic [1:0] st, input int cnt, input logic to);
    exp_t e;
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = bt; mem_req = rq; mem_ready = rdy;
    e.v = {ctl, st, 4'(cnt), to};
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string nm, input logic [1:0] st, input int cnt);
    cyc(nm, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ALL, st, cnt, 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    quiet("reset", 2'd0, 0);
    rst = 1'b1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [12:0] act;
      e = q.pop_front();
      act = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, ctrl_state, stall_count, mem_timeout};
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got ctl=%b st=%0d cnt=%0d to=%b, expected ctl=%b st=%0d cnt=%0d to=%b",
                 e.nm, act[12:7], act[6:5], act[4:1], act[0], e.v[12:7], e.v[6:5], e.v[4:1], e.v[0]);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    cyc("load_use_rs1", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 2'd0, 0, 1'b0);
    cyc("after_load", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ALL, 2'd0, 1, 1'b0);
    cyc("x0_no_stall", 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ALL, 2'd0, 1, 1'b0);
    cyc("unused_rs2", 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, ALL, 2'd0, 1, 1'b0);
    cyc("load_use_rs2", 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, 2'd0, 1, 1'b0);
    cyc("branch_over_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR, 2'd0, 2, 1'b0);
    quiet("after_branch", 2'd0, 2);
    do_reset();
    cyc("wait1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, 2'd0, 0, 1'b0);
    cyc("wait2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, 2'd1, 1, 1'b0);
    cyc("wait3", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, 2'd1, 2, 1'b0);
    cyc("release_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR, 2'd1, 3, 1'b0);
    quiet("back_to_run", 2'd0, 3);
    do_reset();
    for (int i = 1; i <= 15; i++)
      cyc("near_timeout", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,
          (i == 1) ? 2'd0 : 2'd1, i - 1, 1'b0);
    cyc("release_15", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ALL, 2'd1, 15, 1'b0);
    quiet("run_after_15", 2'd0, 15);
    do_reset();
    for (int i = 1; i <= 16; i++)
      cyc("timeout_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,
          (i == 1) ? 2'd0 : 2'd1, i - 1, 1'b0);
    cyc("err_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FRZ, 2'd2, 15, 1'b1);
    cyc("err_branch", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 2'd2, 15, 1'b1);
    do_reset();
    quiet("run_after_err", 2'd0, 0);
    for (int i = 1; i <= 20; i++)
      cyc("saturate", 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU, 2'd0,
          (i > 16) ? 15 : i - 1, 1'b0);
    quiet("saturated", 2'd0, 15);
    @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
